// File: rtl/seq_subtractor.sv
// Bit-serial subtractor with valid/ready handshakes on both sides.
// Computes D = A - B - Bin one bit per clock, LSB first, then holds the
// result until the consumer takes it.
// Optional feature: define SUB_OVERFLOW_EN to add the registered signed
// overflow output 'ovf'.
module seq_subtractor #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            Bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] D,
    output logic            Bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic            ovf
`endif
);

    // Counter must be able to hold SIZE so it never wraps inside BUSY.
    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic [SIZE-1:0] res_q, res_d;
    logic [SIZE-1:0] d_q, d_d;
    logic            br_q, br_d;
    logic            bout_q, bout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef SUB_OVERFLOW_EN
    logic            ovf_q, ovf_d;
`endif

    logic            diff_bit;
    logic            br_next;
    logic            last_bit;
    logic [SIZE-1:0] res_shift;

    // One full-subtractor cell working on the current LSBs of the operands.
    always_comb begin
        diff_bit  = a_q[0] ^ b_q[0] ^ br_q;
        br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        last_bit  = (cnt_q == CW'(SIZE - 1));
        res_shift = res_q >> 1;
        res_shift[SIZE-1] = diff_bit;
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        d_d       = d_q;
        br_d      = br_q;
        bout_d    = bout_q;
        cnt_d     = cnt_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_shift;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    // Publish the result only now so D/Bout stay put while bits are in flight.
                    d_d     = res_shift;
                    bout_d  = br_next;
`ifdef SUB_OVERFLOW_EN
                    ovf_d   = (a_q[0] != b_q[0]) && (diff_bit != a_q[0]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SUB_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign D    = d_q;
    assign Bout = bout_q;
`ifdef SUB_OVERFLOW_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// Testbench for seq_subtractor (SIZE = 8), randomized against an arithmetic
// reference model. Overflow checks are included when SUB_OVERFLOW_EN is defined.
module tb_seq_subtractor;

    localparam int SIZE = 8;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic            Bin;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] D;
    logic            Bout;
`ifdef SUB_OVERFLOW_EN
    logic            ovf;
`endif

    int vectors;
    int miscompares;

    seq_subtractor #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer subtraction, wrapped to SIZE bits.
    function automatic logic [SIZE-1:0] model_d(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bin);
        int r;
        r = int'(a) - int'(b) - int'(bin);
        return SIZE'(r);
    endfunction

    function automatic logic model_bout(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bin);
        return int'(a) < (int'(b) + int'(bin));
    endfunction

    function automatic logic model_ovf(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic [SIZE-1:0] d);
        return (a[SIZE-1] != b[SIZE-1]) && (d[SIZE-1] != a[SIZE-1]);
    endfunction

    // Runs one full transaction with out_ready held high and reports what was seen.
    task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bin,
                          output logic [SIZE-1:0] d, output logic bout, output logic ov,
                          output int lat, output logic ready_after);
        @(negedge clk);
        A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = SIZE'($urandom); B = SIZE'($urandom); Bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d    = D;
        bout = Bout;
`ifdef SUB_OVERFLOW_EN
        ov   = ovf;
`else
        ov   = 1'b0;
`endif
        @(posedge clk);
        #1;
        ready_after = in_ready && !out_valid;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
        rst = 1'b1;
        #12;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++;
        if (D !== '0) begin miscompares++; $display("[TB] FAIL reset_D got %h want 00", D); end
        vectors++;
        if (Bout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_Bout got %b want 0", Bout); end
`ifdef SUB_OVERFLOW_EN
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Checks one operand triple end to end: value, borrow, latency and return to idle.
    task automatic check_op(input string name, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bin);
        logic [SIZE-1:0] d;
        logic bout, ov, rdy;
        logic [SIZE-1:0] ed;
        int lat;
        run_op(a, b, bin, d, bout, ov, lat, rdy);
        ed = model_d(a, b, bin);
        vectors++;
        if (lat !== SIZE) begin miscompares++; $display("[TB] FAIL %s_latency got %0d want %0d", name, lat, SIZE); end
        vectors++;
        if (d !== ed) begin miscompares++; $display("[TB] FAIL %s_D a=%h b=%h bin=%b got %h want %h", name, a, b, bin, d, ed); end
        vectors++;
        if (bout !== model_bout(a, b, bin)) begin miscompares++; $display("[TB] FAIL %s_Bout a=%h b=%h bin=%b got %b want %b", name, a, b, bin, bout, model_bout(a, b, bin)); end
        vectors++;
        if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_ready_after got %b want 1", name, rdy); end
`ifdef SUB_OVERFLOW_EN
        vectors++;
        if (ov !== model_ovf(a, b, ed)) begin miscompares++; $display("[TB] FAIL %s_ovf a=%h b=%h got %b want %b", name, a, b, ov, model_ovf(a, b, ed)); end
`endif
    endtask

    task automatic test_directed();
        check_op("dir_05_03", 8'h05, 8'h03, 1'b0);
        check_op("dir_00_01", 8'h00, 8'h01, 1'b0);
        check_op("dir_10_10_bin", 8'h10, 8'h10, 1'b1);
        check_op("dir_ff_00", 8'hFF, 8'h00, 1'b0);
        check_op("dir_00_ff_bin", 8'h00, 8'hFF, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            check_op("rand", SIZE'($urandom), SIZE'($urandom), 1'($urandom));
        end
    endtask

    // Result must stay frozen and new operands must be refused while the consumer stalls.
    task automatic test_backpressure();
        logic [SIZE-1:0] a, b, ed;
        logic bin;
        int lat;
        a = SIZE'($urandom); b = SIZE'($urandom); bin = 1'($urandom);
        ed = model_d(a, b, bin);
        @(negedge clk);
        A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        A = ~a; B = ~b; Bin = ~bin;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== SIZE) begin miscompares++; $display("[TB] FAIL bp_latency got %0d want %0d", lat, SIZE); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (D !== ed || Bout !== model_bout(a, b, bin) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_hold cycle %0d got D=%h Bout=%b ov=%b ir=%b want D=%h Bout=%b ov=1 ir=0",
                         c, D, Bout, out_valid, in_ready, ed, model_bout(a, b, bin));
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
        end
        in_valid = 1'b0;
    endtask

    // Reset in the third BUSY cycle aborts the job; the next job must still be right.
    task automatic test_reset_busy();
        @(negedge clk);
        A = 8'h5A; B = 8'h21; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== '0 || Bout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_busy got ov=%b ir=%b D=%h Bout=%b want ov=0 ir=1 D=00 Bout=0", out_valid, in_ready, D, Bout);
        end
        @(negedge clk);
        rst = 1'b0;
        check_op("after_rst", 8'h3C, 8'h4D, 1'b1);
    endtask

`ifdef SUB_OVERFLOW_EN
    task automatic test_overflow();
        check_op("ovf_80_01", 8'h80, 8'h01, 1'b0);
        check_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0);
        check_op("ovf_7f_ff", 8'h7F, 8'hFF, 1'b0);
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_busy();
`ifdef SUB_OVERFLOW_EN
        test_overflow();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
